alu_serial_ctrl: RTL and testbench
==================================

// Module: alu_serial_ctrl
// PURPOSE
//  Bit-serial sequencer for one external 1-bit ALU cell (inputs ainv/binv/ci/op/a/b/less; outputs result/co/set).
//  Takes a WIDTH-bit operation, drives the cell LSB-first for WIDTH cycles and carries co between bits.
//  Assembles result, zero and overflow, then returns them over a valid/ready handshake.
//  Sits between the decode stage (alu_ctl) and a single shared ALU cell: an area-minimal ALU.
// PARAMETERS
//  WIDTH   32   operand/result width in bits (>=2)
// PORTS
//  clk           in   1      clock, all state rises on posedge
//  rst_n         in   1      asynchronous active-low reset
//  start_valid   in   1      operation request
//  start_ready   out  1      controller idle, request accepted when start_valid&start_ready
//  alu_ctl       in   4      0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
//  a, b          in   WIDTH  operands, sampled on accept only
//  res_valid     out  1      result available
//  res_ready     in   1      consumer accepts result when res_valid&res_ready
//  result        out  WIDTH  assembled result
//  zero          out  1      result==0
//  overflow      out  1      signed overflow (ADD/SUB/SLT; else 0)
//  illegal       out  1      alu_ctl was not one of the six codes
//  cell_a_invert/cell_b_invert/cell_ci/cell_a/cell_b/cell_less  out 1  drive to cell
//  cell_op       out  2      00 and, 01 or, 10 sum, 11 less
//  cell_result/cell_co/cell_set  in 1  from cell (combinational through cell)
// BEHAVIOUR
//  States IDLE -> RUN -> DONE -> IDLE. start_ready = (state==IDLE), including during reset.
//  Reset (async, any state, mid-RUN included): state IDLE, bit counter 0, carry 0.
//   Reset also clears res_valid, result, zero, overflow, illegal and all cell_* outputs.
//  IDLE: on accept, latch a, b, decoded ctl into shift regs; counter<=0; carry<=b_invert. Go RUN.
//  Decode (a_inv,b_inv,op): AND 0,0,00; OR 0,0,01; ADD 0,0,10; SUB 0,1,10; SLT 0,1,11; NOR 1,1,00.
//   Illegal: decode as AND and set illegal; result forced 0, zero 1, overflow 0.
//  RUN cycle i (0..WIDTH-1): cell_a=a[i], cell_b=b[i], cell_ci=carry, cell_less=0.
//   Each cycle: result[i]<=cell_result and carry<=cell_co.
//   cell_* outputs are 0 outside RUN.
//  At i==WIDTH-1: overflow<=carry^cell_co for ADD/SUB/SLT; capture set_msb<=cell_set. Go DONE.
//  DONE: res_valid=1. For SLT, result = {WIDTH-1 zeros, slt_bit}; zero from final result.
//   result/zero/overflow/illegal held stable while res_valid & !res_ready.
//   On res_ready: res_valid<=0 next cycle, go IDLE. Outputs keep last value until next DONE.
//  Latency: accept edge -> res_valid high after exactly WIDTH+1 rising edges. Throughput: 1 op per WIDTH+2 cycles minimum.
//  start_valid is ignored outside IDLE. No back-to-back accept in the DONE->IDLE cycle.
//  Counter is $clog2(WIDTH) bits and never wraps: terminal compare at WIDTH-1.
// CONFIGURATION
//  SLT_OVF_FIX_EN defined: slt_bit = set_msb ^ overflow, which gives a correct signed compare under overflow.
//  Not defined: slt_bit = set_msb, the raw sign of a-b, matching the combinational ALU.
// TESTING (WIDTH=8, cell model = the team's 1-bit ALU cell)
//  ADD a=0x7F b=0x01 -> result 0x80, overflow 1, zero 0, res_valid exactly 9 edges after accept.
//  SUB a=0x05 b=0x05 -> 0x00, zero 1, overflow 0. NOR a=0xF0 b=0x0F -> 0x00, zero 1. OR/AND 0xA5,0x3C -> 0xBD/0x24.
//  SLT a=0x03 b=0x05 -> 0x01; a=0x05 b=0x03 -> 0x00.
//   SLT a=0x80 b=0x01 -> 0x00 without SLT_OVF_FIX_EN, 0x01 with it; overflow 1 in both builds.
//  Backpressure: hold res_ready=0 for 5 cycles -> result/flags stable, start_ready 0, concurrent start_valid not accepted.
//  Reset asserted at RUN bit 4 -> all outputs 0 immediately, IDLE. Next ADD 0x12+0x34 -> 0x46 with no carry leakage.
//  alu_ctl=0101 a=0xFF b=0xFF -> illegal 1, result 0x00, zero 1; following legal op clears illegal.

Source files
------------

// File: rtl/alu_serial_ctrl.sv
// rtl/alu_serial_ctrl.sv - bit-serial sequencer for one shared 1-bit ALU cell (optional SLT_OVF_FIX_EN)
module alu_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal,
  output logic             cell_a_invert,
  output logic             cell_b_invert,
  output logic             cell_ci,
  output logic             cell_a,
  output logic             cell_b,
  output logic             cell_less,
  output logic [1:0]       cell_op,
  input  logic             cell_result,
  input  logic             cell_co,
  input  logic             cell_set
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, next_state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_sh, b_sh, acc;
  logic             a_inv_q, b_inv_q, ill_q;
  logic [1:0]       op_q;

  logic             dec_a_inv, dec_b_inv, dec_ill;
  logic [1:0]       dec_op;
  logic             accept, last_bit, ovf_now, slt_bit;
  logic [WIDTH-1:0] final_res;

  assign start_ready = (state == IDLE);
  assign res_valid   = (state == DONE);
  assign accept      = start_valid & start_ready;
  assign last_bit    = (state == RUN) && (cnt == LAST);

  // Cell drive is gated to RUN so the shared cell sees zeros whenever it is not ours.
  assign cell_a_invert = (state == RUN) & a_inv_q;
  assign cell_b_invert = (state == RUN) & b_inv_q;
  assign cell_ci       = (state == RUN) & carry;
  assign cell_a        = (state == RUN) & a_sh[0];
  assign cell_b        = (state == RUN) & b_sh[0];
  assign cell_less     = 1'b0;
  assign cell_op       = (state == RUN) ? op_q : 2'b00;

  // Decode alu_ctl into cell controls; unknown codes fall back to AND and raise illegal.
  always_comb begin
    dec_a_inv = 1'b0;
    dec_b_inv = 1'b0;
    dec_op    = 2'b00;
    dec_ill   = 1'b0;
    case (alu_ctl)
      4'b0000: dec_op = 2'b00;
      4'b0001: dec_op = 2'b01;
      4'b0010: dec_op = 2'b10;
      4'b0110: begin dec_b_inv = 1'b1; dec_op = 2'b10; end
      4'b0111: begin dec_b_inv = 1'b1; dec_op = 2'b11; end
      4'b1100: begin dec_a_inv = 1'b1; dec_b_inv = 1'b1; dec_op = 2'b00; end
      default: dec_ill = 1'b1;
    endcase
  end

  // Final-bit result assembly: only meaningful while last_bit is high.
  always_comb begin
    ovf_now = op_q[1] & (carry ^ cell_co);
`ifdef SLT_OVF_FIX_EN
    slt_bit = cell_set ^ ovf_now;
`else
    slt_bit = cell_set;
`endif
    if (ill_q)
      final_res = '0;
    else if (op_q == 2'b11)
      final_res = WIDTH'(slt_bit);
    else
      final_res = {cell_result, acc[WIDTH-1:1]};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = RUN;
      RUN:     if (cnt == LAST) next_state = DONE;
      DONE:    if (res_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand shifting, carry chaining and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      carry    <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      acc      <= '0;
      a_inv_q  <= 1'b0;
      b_inv_q  <= 1'b0;
      op_q     <= 2'b00;
      ill_q    <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      carry   <= dec_b_inv;
      a_sh    <= a;
      b_sh    <= b;
      acc     <= '0;
      a_inv_q <= dec_a_inv;
      b_inv_q <= dec_b_inv;
      op_q    <= dec_op;
      ill_q   <= dec_ill;
    end else if (state == RUN) begin
      carry <= cell_co;
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      acc   <= {cell_result, acc[WIDTH-1:1]};
      if (last_bit) begin
        result   <= final_res;
        zero     <= (final_res == '0);
        overflow <= ovf_now & ~ill_q;
        illegal  <= ill_q;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb/tb_alu_serial_ctrl.sv - directed self-checking bench for alu_serial_ctrl with a 1-bit ALU cell model
module tb_alu_serial_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start_valid, start_ready;
  logic [3:0]       alu_ctl;
  logic [WIDTH-1:0] a, b;
  logic             res_valid, res_ready;
  logic [WIDTH-1:0] result;
  logic             zero, overflow, illegal;
  logic             cell_a_invert, cell_b_invert, cell_ci, cell_a, cell_b, cell_less;
  logic [1:0]       cell_op;
  logic             cell_result, cell_co, cell_set;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_valid(start_valid), .start_ready(start_ready),
    .alu_ctl(alu_ctl), .a(a), .b(b),
    .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .zero(zero), .overflow(overflow), .illegal(illegal),
    .cell_a_invert(cell_a_invert), .cell_b_invert(cell_b_invert),
    .cell_ci(cell_ci), .cell_a(cell_a), .cell_b(cell_b), .cell_less(cell_less),
    .cell_op(cell_op),
    .cell_result(cell_result), .cell_co(cell_co), .cell_set(cell_set)
  );

  // 1-bit ALU cell model
  logic aa, bb, sum;
  assign aa  = cell_a ^ cell_a_invert;
  assign bb  = cell_b ^ cell_b_invert;
  assign sum = aa ^ bb ^ cell_ci;
  assign cell_co  = (aa & bb) | (aa & cell_ci) | (bb & cell_ci);
  assign cell_set = sum;
  assign cell_result = (cell_op == 2'b00) ? (aa & bb) :
                       (cell_op == 2'b01) ? (aa | bb) :
                       (cell_op == 2'b10) ? sum : cell_less;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"}, 32'(start_ready), 32'd1);
    check_eq({tag, "_outs"}, {20'd0, res_valid, result, zero, overflow, illegal}, 32'd0);
    check_eq({tag, "_cell"}, {24'd0, cell_a_invert, cell_b_invert, cell_ci, cell_a,
                              cell_b, cell_less, cell_op}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [3:0] ctl, input logic [7:0] av,
                        input logic [7:0] bv, input logic [7:0] er, input logic ez,
                        input logic eo, input logic ei, input int bp);
    int edges;
    @(negedge clk);
    check_eq({tag, "_start_ready"}, 32'(start_ready), 32'd1);
    start_valid = 1'b1; alu_ctl = ctl; a = av; b = bv;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    start_valid = 1'b0; a = 8'h00; b = 8'h00;
    while (!res_valid && edges < 40) begin
      @(posedge clk); edges++; @(negedge clk);
    end
    check_eq({tag, "_latency"}, 32'(edges), 32'(WIDTH + 1));
    check_eq({tag, "_result"}, 32'(result), 32'(er));
    check_eq({tag, "_flags"}, {29'd0, zero, overflow, illegal}, {29'd0, ez, eo, ei});
    for (int i = 0; i < bp; i++) begin
      start_valid = 1'b1; alu_ctl = 4'b0010; a = 8'h11; b = 8'h22;
      @(posedge clk); @(negedge clk);
      check_eq({tag, "_bp_hold"}, {20'd0, res_valid, start_ready, result, zero, overflow, illegal},
               {20'd0, 1'b1, 1'b0, er, ez, eo, ei});
    end
    res_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    res_ready = 1'b0; start_valid = 1'b0;
    check_eq({tag, "_release"}, {30'd0, res_valid, start_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    check_eq({tag, "_idle_kept"}, {22'd0, start_ready, result, illegal}, {22'd0, 1'b1, er, ei});
  endtask

  initial begin
    logic [7:0] slt_ovf_exp;
`ifdef SLT_OVF_FIX_EN
    slt_ovf_exp = 8'h01;
`else
    slt_ovf_exp = 8'h00;
`endif
    rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0;
    alu_ctl = 4'b0000; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    run_op("add_ovf", 4'b0010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 0);

    // reset during RUN bit 4
    @(negedge clk);
    start_valid = 1'b1; alu_ctl = 4'b0010; a = 8'hFF; b = 8'h01;
    @(posedge clk); @(negedge clk);
    start_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check_eq("midrun_cell_a", 32'(cell_a), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_after_rst", 4'b0010, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0, 0);
    run_op("sub_eq",  4'b0110, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 0);
    run_op("nor",     4'b1100, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b0, 0);
    run_op("or",      4'b0001, 8'hA5, 8'h3C, 8'hBD, 1'b0, 1'b0, 1'b0, 0);
    run_op("and_bp",  4'b0000, 8'hA5, 8'h3C, 8'h24, 1'b0, 1'b0, 1'b0, 5);
    run_op("slt_lt",  4'b0111, 8'h03, 8'h05, 8'h01, 1'b0, 1'b0, 1'b0, 0);
    run_op("slt_gt",  4'b0111, 8'h05, 8'h03, 8'h00, 1'b1, 1'b0, 1'b0, 0);
    run_op("slt_ovf", 4'b0111, 8'h80, 8'h01, slt_ovf_exp, (slt_ovf_exp == 8'h00), 1'b1, 1'b0, 0);
    run_op("illegal", 4'b0101, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 0);
    run_op("legal_clr", 4'b0001, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
